// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with frame-aligned commit.
// Optional leading-zero blanking when SEG7_LZB_EN is defined.
module seg7_scan_driver #(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(N_DIGITS - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*N_DIGITS-1:0]   stg_data_q, act_data_q;
    logic [N_DIGITS-1:0]     stg_dp_q, act_dp_q;
    logic [N_DIGITS-1:0]     stg_en_q, act_en_q;
    logic                    pend_q;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [N_DIGITS-1:0]     an_q, an_d;
    logic                    fd_q;

    logic                    tick, bnd;
    logic [N_DIGITS-1:0]     lzb;
    logic [3:0]              nib;
    logic                    dp_sel;
    logic                    vis;

    function automatic logic [6:0] font(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick = (presc_q == P_LAST);
    assign bnd  = tick && (idx_q == I_LAST);

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tick) idx_d = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
    end

`ifdef SEG7_LZB_EN
    logic zrun;
    // Walk from the top digit down; a zero run ends at the first non-blank enabled digit.
    always_comb begin
        lzb  = '0;
        zrun = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (act_en_q[i])
                zrun = zrun & (act_data_q[4*i +: 4] == 4'h0) & ~act_dp_q[i];
            if (i > 0) lzb[i] = zrun;
        end
    end
`else
    assign lzb = '0;
`endif

    always_comb begin
        nib    = 4'h0;
        dp_sel = 1'b0;
        vis    = 1'b0;
        an_d   = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (IW'(i) == idx_q) begin
                nib     = act_data_q[4*i +: 4];
                dp_sel  = act_dp_q[i];
                vis     = act_en_q[i] & ~lzb[i];
                an_d[i] = ~(act_en_q[i] & ~lzb[i]);
            end
        end
        seg_d = vis ? font(nib) : 7'h7F;
        dp_d  = vis ? ~dp_sel : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            idx_q      <= '0;
            stg_data_q <= '0;
            stg_dp_q   <= '0;
            stg_en_q   <= '0;
            act_data_q <= '0;
            act_dp_q   <= '0;
            act_en_q   <= '0;
            pend_q     <= 1'b0;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            an_q       <= '1;
            fd_q       <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            fd_q    <= bnd;
            // Commit uses the pre-edge staging, so a same-cycle load waits a frame.
            if (bnd && pend_q) begin
                act_data_q <= stg_data_q;
                act_dp_q   <= stg_dp_q;
                act_en_q   <= stg_en_q;
            end
            if (load) begin
                stg_data_q <= data_in;
                stg_dp_q   <= dp_in;
                stg_en_q   <= digit_en;
                pend_q     <= 1'b1;
            end else if (bnd) begin
                pend_q     <= 1'b0;
            end
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized + directed bench for seg7_scan_driver (N_DIGITS=4, REFRESH_DIV=4).
// Cycle-count reference model; LZB expectations follow SEG7_LZB_EN.
module tb_seg7_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int FR  = N * DIV;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [15:0]   data_in = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    digit_en = '0;
    logic          load = 1'b0;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_on  = 1'b0;

    logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                              7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                              7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
        .digit_en(digit_en), .load(load), .seg(seg), .dp(dp), .an(an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    // Reference model: cycle count since reset decides slot and frame end.
    int          m_c;
    int          m_slot;
    logic [15:0] m_sdat, m_adat;
    logic [3:0]  m_sdp, m_adp, m_sen, m_aen;
    bit          m_pend;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;

    function automatic bit shown(input int i);
        bit allz;
        if (!m_aen[i]) return 1'b0;
`ifdef SEG7_LZB_EN
        if (i > 0) begin
            allz = 1'b1;
            for (int j = i; j < N; j++)
                if (m_aen[j] && (m_adat[4*j +: 4] != 4'h0 || m_adp[j]))
                    allz = 1'b0;
            if (allz) return 1'b0;
        end
`else
        allz = 1'b0;
`endif
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_c = 0; m_pend = 0;
            m_sdat = '0; m_sdp = '0; m_sen = '0;
            m_adat = '0; m_adp = '0; m_aen = '0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
        end else begin
            m_slot = (m_c / DIV) % N;
            if (shown(m_slot)) begin
                e_an = ~(4'b0001 << m_slot);
                e_seg = FONT[m_adat[4*m_slot +: 4]];
                e_dp = ~m_adp[m_slot];
            end else begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end
            e_fd = ((m_c % FR) == FR - 1);
            if (e_fd && m_pend) begin
                m_adat = m_sdat; m_adp = m_sdp; m_aen = m_sen; m_pend = 0;
            end
            if (load) begin
                m_sdat = data_in; m_sdp = dp_in; m_sen = digit_en; m_pend = 1;
            end
            m_c++;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_an", 32'(an), 32'(e_an));
            chk("cyc_seg", 32'(seg), 32'(e_seg));
            chk("cyc_dp", 32'(dp), 32'(e_dp));
            chk("cyc_fd", 32'(frame_done), 32'(e_fd));
        end
    end

    task automatic do_load(input logic [15:0] d, input logic [3:0] p,
                           input logic [3:0] e);
        data_in = d; dp_in = p; digit_en = e; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_fd();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (frame_done) return;
        end
        chk("fd_timeout", 32'd0, 32'd1);
    endtask

    logic [3:0] an_e  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] seg_e [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
    logic       dp_e  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] an6   [4];
    logic [6:0] seg6  [4];

    initial begin
        int fdc;
        #2 rst_n = 1'b0;
        #1 cmp_on = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_fd", 32'(frame_done), 32'h0);

        fdc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (frame_done) fdc++;
        end
        chk("idle_fd_count", 32'(fdc), 32'd2);
        chk("idle_an", 32'(an), 32'hF);

        do_load(16'h12AF, 4'b0100, 4'hF);
        wait_fd();
        for (int k = 0; k < FR; k++) begin
            @(negedge clk);
            if (k % DIV == 0) begin
                chk("t2_an", 32'(an), 32'(an_e[k/DIV]));
                chk("t2_seg", 32'(seg), 32'(seg_e[k/DIV]));
                chk("t2_dp", 32'(dp), 32'(dp_e[k/DIV]));
            end
        end

        wait_fd();
        do_load(16'h1111, 4'h0, 4'hF);
        repeat (3) @(negedge clk);
        do_load(16'h2222, 4'h0, 4'hF);
        wait_fd();
        for (int k = 0; k < FR; k++) begin
            @(negedge clk);
            chk("t3_no1111", 32'(seg), 32'h24);
        end
        repeat (FR - 1) @(negedge clk);
        do_load(16'h3333, 4'h0, 4'hF);
        chk("t3_bnd_fd", 32'(frame_done), 32'h1);
        @(negedge clk);
        chk("t3_deferred", 32'(seg), 32'h24);
        wait_fd();
        @(negedge clk);
        chk("t3_commit", 32'(seg), 32'h30);

        wait_fd();
        repeat (2 * DIV) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_an", 32'(an), 32'hF);
        chk("t4_seg", 32'(seg), 32'h7F);
        chk("t4_dp", 32'(dp), 32'h1);
        chk("t4_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * FR) @(negedge clk);
        chk("t4_dark", 32'(an), 32'hF);

        for (int v = 0; v < 16; v++) begin
            do_load({12'h000, 4'(v)}, 4'h0, 4'h1);
            wait_fd();
            @(negedge clk);
            chk("t5_font", 32'(seg), 32'(FONT[v]));
        end

`ifdef SEG7_LZB_EN
        an6  = '{4'hE, 4'hD, 4'hF, 4'hF};
        seg6 = '{7'h40, 7'h12, 7'h7F, 7'h7F};
`else
        an6  = '{4'hE, 4'hD, 4'hB, 4'h7};
        seg6 = '{7'h40, 7'h12, 7'h40, 7'h40};
`endif
        do_load(16'h0050, 4'h0, 4'hF);
        wait_fd();
        for (int k = 0; k < FR; k++) begin
            @(negedge clk);
            if (k % DIV == 0) begin
                chk("t6_an", 32'(an), 32'(an6[k/DIV]));
                chk("t6_seg", 32'(seg), 32'(seg6[k/DIV]));
            end
        end
        do_load(16'h0000, 4'h0, 4'hF);
        wait_fd();
        repeat (3 * DIV + 1) @(negedge clk);
`ifdef SEG7_LZB_EN
        chk("t6_zero_d3", 32'(an), 32'hF);
`else
        chk("t6_zero_d3", 32'(an), 32'h7);
`endif

        for (int r = 0; r < 40; r++) begin
            data_in  = 16'($urandom);
            dp_in    = 4'($urandom);
            digit_en = 4'($urandom);
            load     = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            load = 1'b0;
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        repeat (2 * FR) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
